// File: rtl/bsg_manycore_remote_req_issue.sv
// One-entry remote request issue stage: holds a translated request until the network
// takes it, gated by an outstanding-credit counter. Optional fence: BSG_MANYCORE_REQ_ISSUE_FENCE_EN.
module bsg_manycore_remote_req_issue #(
  parameter int x_cord_width_p    = 4,
  parameter int y_cord_width_p    = 4,
  parameter int addr_width_p      = 16,
  parameter int data_width_p      = 32,
  parameter int max_out_credits_p = 2,
  localparam int credit_width_lp  = $clog2(max_out_credits_p+1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        v_i,
  output logic                        ready_o,
  input  logic [x_cord_width_p-1:0]   x_cord_i,
  input  logic [y_cord_width_p-1:0]   y_cord_i,
  input  logic [addr_width_p-1:0]     epa_i,
  input  logic                        is_invalid_addr_i,
  input  logic                        we_i,
  input  logic [data_width_p/8-1:0]   mask_i,
  input  logic [data_width_p-1:0]     data_i,
  input  logic                        fence_i,

  output logic                        v_o,
  input  logic                        yumi_i,
  output logic [x_cord_width_p-1:0]   x_cord_o,
  output logic [y_cord_width_p-1:0]   y_cord_o,
  output logic [addr_width_p-1:0]     addr_o,
  output logic                        we_o,
  output logic [data_width_p/8-1:0]   mask_o,
  output logic [data_width_p-1:0]     data_o,

  input  logic                        credit_return_i,
  output logic [credit_width_lp-1:0]  out_credits_o,
  output logic                        fault_v_o,
  output logic [addr_width_p-1:0]     fault_addr_o,
  output logic                        credit_error_o
);

  typedef enum logic [1:0] {EMPTY, SEND, FENCE_WAIT} state_e;

  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  state_e                       state_q, state_d;
  logic [credit_width_lp-1:0]   credits_q, credits_d;
  logic                         cred_err_q, cred_err_d;
  logic                         fault_v_q, fault_v_d;
  logic [addr_width_p-1:0]      fault_addr_q, fault_addr_d;
  logic [x_cord_width_p-1:0]    x_q, x_d;
  logic [y_cord_width_p-1:0]    y_q, y_d;
  logic [addr_width_p-1:0]      addr_q, addr_d;
  logic                         we_q, we_d;
  logic [data_width_p/8-1:0]    mask_q, mask_d;
  logic [data_width_p-1:0]      data_q, data_d;

  logic accept, fence_acc, req_acc, load, send, credits_max;

`ifdef BSG_MANYCORE_REQ_ISSUE_FENCE_EN
  assign fence_acc = accept & fence_i;
`else
  logic unused_fence;
  assign unused_fence = fence_i;
  assign fence_acc    = 1'b0;
`endif

  always_comb begin
    credits_max = (credits_q == max_credits_lp);
    v_o         = (state_q == SEND) & (credits_q != '0);
    send        = v_o & yumi_i;
    ready_o     = (state_q == EMPTY) | ((state_q == SEND) & yumi_i);
    accept      = v_i & ready_o;
    req_acc     = accept & ~fence_acc;
    load        = req_acc & ~is_invalid_addr_i;

    state_d = state_q;
    unique case (state_q)
      EMPTY:      if (load) state_d = SEND;
      SEND:       if (yumi_i) state_d = load ? SEND : EMPTY;
      FENCE_WAIT: if (credits_max) state_d = EMPTY;
      default:    state_d = EMPTY;
    endcase
    if (fence_acc) state_d = FENCE_WAIT;

    // A return alongside a send cancels out; a lone return at max is a protocol error.
    credits_d  = credits_q;
    cred_err_d = cred_err_q;
    if (credit_return_i & ~send) begin
      if (credits_max) cred_err_d = 1'b1;
      else             credits_d  = credits_q + credit_width_lp'(1);
    end else if (send & ~credit_return_i) begin
      credits_d = credits_q - credit_width_lp'(1);
    end

    fault_v_d    = req_acc & is_invalid_addr_i;
    fault_addr_d = fault_v_d ? epa_i : fault_addr_q;

    x_d    = load ? x_cord_i : x_q;
    y_d    = load ? y_cord_i : y_q;
    addr_d = load ? epa_i    : addr_q;
    we_d   = load ? we_i     : we_q;
    mask_d = load ? mask_i   : mask_q;
    data_d = load ? data_i   : data_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= EMPTY;
      credits_q    <= max_credits_lp;
      cred_err_q   <= 1'b0;
      fault_v_q    <= 1'b0;
      fault_addr_q <= '0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      mask_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      cred_err_q   <= cred_err_d;
      fault_v_q    <= fault_v_d;
      fault_addr_q <= fault_addr_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      mask_q       <= mask_d;
      data_q       <= data_d;
    end
  end

  assign out_credits_o  = credits_q;
  assign credit_error_o = cred_err_q;
  assign fault_v_o      = fault_v_q;
  assign fault_addr_o   = fault_addr_q;
  assign x_cord_o       = x_q;
  assign y_cord_o       = y_q;
  assign addr_o         = addr_q;
  assign we_o           = we_q;
  assign mask_o         = mask_q;
  assign data_o         = data_q;

endmodule

// File: doc/bsg_manycore_remote_req_issue.md
BSG_MANYCORE_REMOTE_REQ_ISSUE -- requirements
Module: bsg_manycore_remote_req_issue

Interface
REQ-001 x_cord_width_p, "inv", destination x-cord width.
REQ-002 y_cord_width_p, "inv", destination y-cord width.
REQ-003 addr_width_p, "inv", EPA word-address width.
REQ-004 data_width_p, "inv", store data width (32).
REQ-005 max_out_credits_p, "inv", outstanding-request limit (>=1); credit_width = $clog2(max_out_credits_p+1).
REQ-006 clk_i  input  1  sole clock.
REQ-007 reset_i  input  1  synchronous, active-high reset.
REQ-008 v_i  input  1  translated request valid (NPA from EVA-to-NPA stage).
REQ-009 ready_o  output  1  request accepted when v_i & ready_o.
REQ-010 x_cord_i / y_cord_i  input  x_cord_width_p / y_cord_width_p  destination tile.
REQ-011 epa_i  input  addr_width_p  endpoint physical word address.
REQ-012 is_invalid_addr_i  input  1  EVA mapped to no NPA.
REQ-013 we_i  input  1  store (1) / load (0).
REQ-014 mask_i  input  data_width_p/8  byte mask.
REQ-015 data_i  input  data_width_p  store data.
REQ-016 fence_i  input  1  fence request, sampled with v_i.
REQ-017 v_o  output  1  packet valid to network.
REQ-018 yumi_i  input  1  network consumes packet; legal only when v_o=1.
REQ-019 x_cord_o, y_cord_o, addr_o, we_o, mask_o, data_o  output  matching input widths  registered packet fields.
REQ-020 credit_return_i  input  1  one response returned this cycle.
REQ-021 out_credits_o  output  credit_width  available credits.
REQ-022 fault_v_o  output  1  one-cycle pulse, invalid address dropped.
REQ-023 fault_addr_o  output  addr_width_p  epa_i of dropped request, held until next fault.
REQ-024 credit_error_o  output  1  sticky: credit returned while counter at max.

Function
REQ-025 States: EMPTY, SEND, FENCE_WAIT; the one-entry packet register is loaded only on accept.
REQ-026 ready_o = (state==EMPTY) | (state==SEND & yumi_i); no fence in flight.
REQ-027 Accept with is_invalid_addr_i=1: no load, fault_v_o=1 next cycle, fault_addr_o<=epa_i, state unchanged.
REQ-028 Accept of valid request: register fields, state->SEND; packet visible the cycle after accept (1-cycle latency).
REQ-029 v_o = (state==SEND) & (out_credits_o!=0); fields stable while v_o & ~yumi_i.
REQ-030 SEND & yumi_i with no new accept -> EMPTY; with accept -> SEND, new packet back-to-back.
REQ-031 Counter: -1 on v_o&yumi_i, +1 on credit_return_i, unchanged when both occur.
REQ-032 credit_return_i at max (no send): counter holds max, credit_error_o<=1.
REQ-033 Fence accept (fence_i & v_i & ready_o, request fields ignored): state->FENCE_WAIT, ready_o=0 until out_credits_o==max_out_credits_p, then EMPTY.
REQ-034 Fence arriving with counter already at max: still one cycle in FENCE_WAIT.

Reset
REQ-035 reset_i: state=EMPTY, out_credits_o=max_out_credits_p, v_o=0, fault_v_o=0, credit_error_o=0, fault_addr_o=0, packet fields=0.
REQ-036 Reset mid-transfer discards the held packet; credit_return_i in the reset cycle is ignored.

Configuration
REQ-037 BSG_MANYCORE_REQ_ISSUE_FENCE_EN defined: REQ-033/034 active; undefined: fence_i ignored, FENCE_WAIT unreachable, fence beat treated as normal request.

Verification
REQ-038 max=2, three stores, yumi_i=1, no returns -> two packets sent, v_o=0, out_credits_o=0; one return -> third sent.
REQ-039 Invalid-address load epa=0x1234 -> fault_v_o single pulse, fault_addr_o=0x1234, v_o stays 0, credits unchanged.
REQ-040 yumi_i=0 for 5 cycles with v_o=1 -> fields constant, ready_o=0; yumi_i=1 with v_i=1 -> next packet following cycle.
REQ-041 Simultaneous send and return at out_credits_o=1 -> stays 1; return at max -> credit_error_o=1 until reset.
REQ-042 FENCE_EN, 2 outstanding, fence -> ready_o=0 until second return, then 1 next cycle; without macro fence_i has no effect.
